// File: rtl/pe_dot_result_drain_if.sv
// Output beat stream of the PE dot-result drain.
// Carries one accumulated element per beat, with its tile coordinates.
interface pe_dot_result_drain_if #(
    parameter int ACC_WIDTH    = 24,
    parameter int NUM_FEATURES = 2,
    parameter int NUM_FILTERS  = 2
);
    localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int KW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

    logic                        o_valid;
    logic                        i_ready;
    logic signed [ACC_WIDTH-1:0] o_data;
    logic [FW-1:0]               o_feature_idx;
    logic [KW-1:0]               o_filter_idx;
    logic                        o_last;

    modport master (
        output o_valid, o_data, o_feature_idx, o_filter_idx, o_last,
        input  i_ready
    );

    modport slave (
        input  o_valid, o_data, o_feature_idx, o_filter_idx, o_last,
        output i_ready
    );
endinterface

// File: rtl/pe_dot_result_drain.sv
// Accumulates aligned dot-array results per tile and drains them as a beat stream.
// Define PE_DRAIN_SATURATE_EN for saturating accumulation (default: wrap-around).
module pe_dot_result_drain #(
    parameter int NUM_FEATURES     = 2,
    parameter int NUM_FILTERS      = 2,
    parameter int DOT_OUTPUT_WIDTH = 16,
    parameter int ACC_WIDTH        = 24,
    parameter int DOT_LATENCY      = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_issue_valid,
    input  logic i_issue_last,
    input  logic [NUM_FEATURES*NUM_FILTERS*DOT_OUTPUT_WIDTH-1:0] i_dot_result,
    output logic o_stall,
    output logic o_overflow,
    pe_dot_result_drain_if.master dout
);
    localparam int N  = NUM_FEATURES * NUM_FILTERS;
    localparam int DW = DOT_OUTPUT_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int KW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int EW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                 state, state_d;
    logic [DOT_LATENCY-1:0] v_sr, l_sr;
    logic                   a_valid, a_last;
    logic                   xfer, pending;
    logic [FW-1:0]          f;
    logic [KW-1:0]          k;
    logic [EW-1:0]          sel;
    logic signed [AW-1:0]   acc   [N];
    logic signed [AW-1:0]   acc_d [N];
    logic signed [AW-1:0]   dbuf  [N];
    logic hs, last_el, last_hs, busy, take, close, load;

    assign a_valid = v_sr[DOT_LATENCY-1];
    assign a_last  = l_sr[DOT_LATENCY-1];
    assign hs      = (state == DRAIN) && dout.i_ready;
    assign last_el = (f == FW'(NUM_FEATURES - 1)) && (k == KW'(NUM_FILTERS - 1));
    assign last_hs = hs && last_el;
    assign busy    = (state == DRAIN) || xfer;
    assign take    = a_valid && !pending;
    assign close   = take && a_last;
    assign load    = (xfer || pending) && ((state == IDLE) || last_hs);
    assign sel     = EW'(f * NUM_FILTERS + k);
    assign o_stall = busy || pending;

    for (genvar e = 0; e < N; e++) begin : g_el
        logic signed [AW-1:0] ext, base, res;
        assign ext  = AW'($signed(i_dot_result[e*DW +: DW]));
        assign base = load ? '0 : acc[e];
`ifdef PE_DRAIN_SATURATE_EN
        localparam logic signed [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
        localparam logic signed [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};
        logic signed [AW:0] sum;
        assign sum = (AW+1)'(base) + (AW+1)'(ext);
        assign res = (sum[AW] != sum[AW-1]) ? (sum[AW] ? SMIN : SMAX)
                                            : sum[AW-1:0];
`else
        assign res = base + ext;
`endif
        assign acc_d[e] = take ? res : base;
    end

    // Delay issue qualifiers so they line up with the dot results.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v_sr <= '0;
            l_sr <= '0;
        end else begin
            v_sr <= (v_sr << 1) | DOT_LATENCY'(i_issue_valid);
            l_sr <= (l_sr << 1) | DOT_LATENCY'(i_issue_valid && i_issue_last);
        end
    end

    // Accumulators and drain buffer; buffer captures the closed sum on load.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int e = 0; e < N; e++) begin
                acc[e]  <= '0;
                dbuf[e] <= '0;
            end
        end else begin
            for (int e = 0; e < N; e++) begin
                acc[e] <= acc_d[e];
                if (load) dbuf[e] <= acc[e];
            end
        end
    end

    // Tile-close bookkeeping: transfer request, pending tile, sticky overflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            xfer       <= 1'b0;
            pending    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            xfer       <= close && !busy;
            pending    <= (pending && !load) || (close && busy);
            o_overflow <= o_overflow || (a_valid && pending);
        end
    end

    // Drain state and filter-minor element walk.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            f     <= '0;
            k     <= '0;
        end else begin
            state <= state_d;
            if (load || last_hs) begin
                f <= '0;
                k <= '0;
            end else if (hs) begin
                if (k == KW'(NUM_FILTERS - 1)) begin
                    k <= '0;
                    f <= f + 1'b1;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end

    // Next-state and beat outputs.
    always_comb begin
        state_d            = state;
        dout.o_valid       = 1'b0;
        dout.o_data        = '0;
        dout.o_feature_idx = f;
        dout.o_filter_idx  = k;
        dout.o_last        = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) state_d = DRAIN;
            end
            DRAIN: begin
                dout.o_valid = 1'b1;
                dout.o_data  = dbuf[sel];
                dout.o_last  = last_el;
                if (last_hs && !load) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pe_dot_result_drain.sv
// Directed bench for pe_dot_result_drain.
// Second instance (ACC_WIDTH=16) covers wrap/saturation.
module tb_pe_dot_result_drain;
    localparam int DW = 16;
    localparam int AW = 24;
    localparam int NF = 2;
    localparam int NK = 2;
    localparam int DL = 4;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    logic iv, il, stall, ovf;
    logic [NF*NK*DW-1:0] dot;
    logic iv2, il2, stall2, ovf2;
    logic [NF*NK*DW-1:0] dot2;

    pe_dot_result_drain_if #(.ACC_WIDTH(AW), .NUM_FEATURES(NF), .NUM_FILTERS(NK)) s1 ();
    pe_dot_result_drain_if #(.ACC_WIDTH(16), .NUM_FEATURES(NF), .NUM_FILTERS(NK)) s2 ();

    pe_dot_result_drain #(
        .NUM_FEATURES(NF), .NUM_FILTERS(NK), .DOT_OUTPUT_WIDTH(DW),
        .ACC_WIDTH(AW), .DOT_LATENCY(DL)
    ) dut (
        .clock(clock), .resetn(resetn), .i_issue_valid(iv), .i_issue_last(il),
        .i_dot_result(dot), .o_stall(stall), .o_overflow(ovf), .dout(s1)
    );

    pe_dot_result_drain #(
        .NUM_FEATURES(NF), .NUM_FILTERS(NK), .DOT_OUTPUT_WIDTH(16),
        .ACC_WIDTH(16), .DOT_LATENCY(DL)
    ) dut2 (
        .clock(clock), .resetn(resetn), .i_issue_valid(iv2), .i_issue_last(il2),
        .i_dot_result(dot2), .o_stall(stall2), .o_overflow(ovf2), .dout(s2)
    );

    int tests = 0;
    int fails = 0;

`ifdef PE_DRAIN_SATURATE_EN
    localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
    localparam logic [15:0] SAT_EXP = 16'hE000;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_dot(input int a, input int b, input int c, input int d);
        dot[0*DW +: DW] = a[15:0];
        dot[1*DW +: DW] = b[15:0];
        dot[2*DW +: DW] = c[15:0];
        dot[3*DW +: DW] = d[15:0];
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (s1.o_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk(tag, 32'(s1.o_valid), 32'd1);
    endtask

    task automatic beat(input string tag, input int d, input int fi, input int ki, input bit l);
        chk({tag, "_v"}, 32'(s1.o_valid), 32'd1);
        chk({tag, "_d"}, 32'(s1.o_data), 32'(d));
        chk({tag, "_f"}, 32'(s1.o_feature_idx), 32'(fi));
        chk({tag, "_k"}, 32'(s1.o_filter_idx), 32'(ki));
        chk({tag, "_l"}, 32'(s1.o_last), 32'(l));
        step();
    endtask

    initial begin
        iv = 0; il = 0; dot = '0;
        iv2 = 0; il2 = 0; dot2 = '0;
        s1.i_ready = 1'b0;
        s2.i_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(s1.o_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_data", 32'(s1.o_data), 32'd0);
        step();
        resetn = 1'b1;

        // single tile, three chunks
        s1.i_ready = 1'b1;
        set_dot(1, 2, 3, 4);
        iv = 1; il = 0;
        step();
        step();
        il = 1;
        step();
        iv = 0; il = 0;
        repeat (4) step();
        chk("lat_early", 32'(s1.o_valid), 32'd0);
        step();
        chk("lat_valid", 32'(s1.o_valid), 32'd1);
        chk("t1_stall", 32'(stall), 32'd1);
        beat("t1b0", 3, 0, 0, 0);
        beat("t1b1", 6, 0, 1, 0);
        beat("t1b2", 9, 1, 0, 0);
        beat("t1b3", 12, 1, 1, 1);
        chk("t1_idle", 32'(s1.o_valid), 32'd0);
        chk("t1_unstall", 32'(stall), 32'd0);

        // backpressure
        set_dot(10, 20, 30, 40);
        iv = 1; il = 1;
        step();
        iv = 0; il = 0;
        wait_valid("t2_wait");
        chk("t2_b0", 32'(s1.o_data), 32'd10);
        step();
        s1.i_ready = 1'b0;
        chk("t2_b1", 32'(s1.o_data), 32'd20);
        chk("t2_b1k", 32'(s1.o_filter_idx), 32'd1);
        step();
        chk("t2_hold", 32'(s1.o_data), 32'd20);
        step();
        s1.i_ready = 1'b1;
        chk("t2_hold2", 32'(s1.o_data), 32'd20);
        chk("t2_holdk", 32'(s1.o_filter_idx), 32'd1);
        step();
        beat("t2b2", 30, 1, 0, 0);
        beat("t2b3", 40, 1, 1, 1);
        chk("t2_idle", 32'(s1.o_valid), 32'd0);

        // back-to-back tiles
        s1.i_ready = 1'b0;
        set_dot(5, 5, 5, 5);
        iv = 1; il = 1;
        step();
        step();
        iv = 0; il = 0;
        step();
        step();
        step();
        set_dot(-7, -7, -7, -7);
        step();
        chk("t3_valid", 32'(s1.o_valid), 32'd1);
        chk("t3_stall", 32'(stall), 32'd1);
        chk("t3_a0", 32'(s1.o_data), 32'd5);
        s1.i_ready = 1'b1;
        beat("t3a0", 5, 0, 0, 0);
        beat("t3a1", 5, 0, 1, 0);
        beat("t3a2", 5, 1, 0, 0);
        beat("t3a3", 5, 1, 1, 1);
        beat("t3b0", -7, 0, 0, 0);
        beat("t3b1", -7, 0, 1, 0);
        beat("t3b2", -7, 1, 0, 0);
        beat("t3b3", -7, 1, 1, 1);
        chk("t3_idle", 32'(s1.o_valid), 32'd0);
        chk("t3_unstall", 32'(stall), 32'd0);
        chk("t3_ovf", 32'(ovf), 32'd0);

        // overflow while pending
        s1.i_ready = 1'b0;
        set_dot(3, 3, 3, 3);
        iv = 1; il = 1;
        step();
        step();
        il = 0;
        step();
        iv = 0;
        step();
        step();
        set_dot(100, 100, 100, 100);
        step();
        set_dot(50, 50, 50, 50);
        step();
        chk("t4_ovf", 32'(ovf), 32'd1);
        chk("t4_stall", 32'(stall), 32'd1);
        s1.i_ready = 1'b1;
        wait_valid("t4_wait");
        beat("t4c0", 3, 0, 0, 0);
        beat("t4c1", 3, 0, 1, 0);
        beat("t4c2", 3, 1, 0, 0);
        beat("t4c3", 3, 1, 1, 1);
        beat("t4d0", 100, 0, 0, 0);
        beat("t4d1", 100, 0, 1, 0);
        beat("t4d2", 100, 1, 0, 0);
        beat("t4d3", 100, 1, 1, 1);
        chk("t4_ovf_sticky", 32'(ovf), 32'd1);

        // reset mid-drain
        set_dot(8, 8, 8, 8);
        iv = 1; il = 1;
        step();
        iv = 0; il = 0;
        wait_valid("t5_wait");
        beat("t5b0", 8, 0, 0, 0);
        beat("t5b1", 8, 0, 1, 0);
        resetn = 1'b0;
        #1;
        chk("t5_rvalid", 32'(s1.o_valid), 32'd0);
        chk("t5_rstall", 32'(stall), 32'd0);
        chk("t5_rovf", 32'(ovf), 32'd0);
        step();
        step();
        resetn = 1'b1;
        set_dot(-1, -2, -3, -4);
        iv = 1; il = 1;
        step();
        iv = 0; il = 0;
        wait_valid("t5_wait2");
        beat("t5n0", -1, 0, 0, 0);
        beat("t5n1", -2, 0, 1, 0);
        beat("t5n2", -3, 1, 0, 0);
        beat("t5n3", -4, 1, 1, 1);

        // wrap / saturation at ACC_WIDTH=16
        s2.i_ready = 1'b1;
        dot2 = {4{16'h7000}};
        iv2 = 1; il2 = 0;
        step();
        il2 = 1;
        step();
        iv2 = 0; il2 = 0;
        begin
            int n;
            n = 0;
            while (s2.o_valid !== 1'b1 && n < 30) begin
                step();
                n++;
            end
        end
        chk("t6_valid", 32'(s2.o_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t6_sat", {16'b0, s2.o_data}, {16'b0, SAT_EXP});
            step();
        end
        chk("t6_idle", 32'(s2.o_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pe_dot_result_drain.md
Name: pe_dot_result_drain

Overview:
- Consumer end of the PE dot-product array.
- Captures the NUM_FEATURES x NUM_FILTERS dot results DOT_LATENCY cycles after each block issue, and accumulates them across DOT_SIZE-chunks of one output pixel.
- On the last chunk, hands the accumulated tile to a drain buffer.
- Drains the buffer one element per beat over a valid/ready stream to the output writer, and back-pressures the issue side when it cannot absorb another tile.

Parameters:
- NUM_FEATURES, 2, features per PE (rows of result array)
- NUM_FILTERS, 2, filters per PE (columns of result array)
- DOT_OUTPUT_WIDTH, 16, signed width of one dot result
- ACC_WIDTH, 24, signed accumulator/output width; must be >= DOT_OUTPUT_WIDTH
- DOT_LATENCY, 4, cycles from block issue to o_dot_result valid; must be >= 1

Ports:
- clock  in  1  sole clock
- resetn  in  1  asynchronous active-low reset
- i_issue_valid  in  1  feature/filter block issued to the dot array this cycle
- i_issue_last  in  1  issued block is last chunk of the accumulation; qualified by i_issue_valid
- i_dot_result  in  NUM_FEATURES*NUM_FILTERS*DOT_OUTPUT_WIDTH  flattened dot results; element [f][k] at index f*NUM_FILTERS+k
- o_stall  out  1  issue side must not assert i_issue_valid while high
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts beat
- o_data  out  ACC_WIDTH  accumulated result, signed
- o_feature_idx  out  $clog2(NUM_FEATURES) min 1  feature index of beat
- o_filter_idx  out  $clog2(NUM_FILTERS) min 1  filter index of beat
- o_last  out  1  final beat of tile
- o_overflow  out  1  sticky protocol error

Behaviour:
- Reset (async, resetn=0) clears:
  - all outputs to 0;
  - accumulators, valid/last delay line, pending flag and drain FSM to IDLE.
- Alignment: i_issue_valid/i_issue_last pass through a DOT_LATENCY-deep shift register. The aligned pair (a_valid, a_last) qualifies i_dot_result in the same cycle.
- Accumulate: on a_valid, acc[f][k] <= acc[f][k] + sext(i_dot_result[f][k]). Sign extension is to ACC_WIDTH.
- First chunk after a transfer starts from 0. Transfer and the next chunk's accumulate may coincide; the new sum then starts from 0 + result.
- Tile close: a_valid & a_last finishes the accumulation (the sum includes that result).
  - If the drain buffer is empty: in the next cycle, copy acc into the drain buffer and clear acc.
  - Otherwise set pending. The transfer happens the cycle after the buffer frees.
- Pending: an a_valid arriving while pending is set sets o_overflow (sticky until reset). Its result is discarded.
- o_stall = drain_busy | pending. It is registered-free combinational from state. In-flight blocks (at most DOT_LATENCY) must not be relied upon by upstream.
- Drain FSM:
  - IDLE: o_valid=0. On buffer load go to DRAIN with f=0, k=0.
  - DRAIN: o_valid=1, o_data=buf[f][k], indices=f,k, o_last=(f==NUM_FEATURES-1 && k==NUM_FILTERS-1).
  - On o_valid & i_ready: k increments; at k wrap, f increments. On the last beat, return to IDLE and mark the buffer empty.
- Order: filter-minor (0,0),(0,1),(1,0),(1,1).
- Output stability: o_data/indices/o_last are held while o_valid & !i_ready.
- Throughput: one beat per cycle under continuous i_ready. There are no bubbles between tiles when a pending tile transfers on the last-beat cycle +1.
- Latency: a_last cycle -> first o_valid = 2 cycles when the buffer is empty.

Optional Feature:
- PE_DRAIN_SATURATE_EN defined: accumulation saturates to the signed ACC_WIDTH range. Max is 2^(ACC_WIDTH-1)-1; min is -2^(ACC_WIDTH-1).
- PE_DRAIN_SATURATE_EN undefined: two's-complement wrap-around at ACC_WIDTH.

Test Plan:
- Single tile, 3 chunks:
  - Stimulus: results [f][k] = {1,2,3,4} each chunk, last on chunk 3, i_ready=1.
  - Response: beats 3,6,9,12 with indices (0,0),(0,1),(1,0),(1,1); o_last on 4th beat; first o_valid 2 cycles after aligned last.
- Backpressure:
  - Stimulus: i_ready toggles 1,0,0,1 during the drain.
  - Response: o_data held stable while stalled; all 4 beats delivered in order; no duplicates.
- Back-to-back tiles:
  - Stimulus: tile A (last at chunk 1, value 5), then tile B (value -7) with i_ready=0.
  - Response: o_stall goes high; B goes pending. After A drains, B beats = -7 with no loss; o_overflow=0.
- Overflow:
  - Stimulus: while pending, inject an extra aligned valid.
  - Response: o_overflow=1 and stays 1; pending tile data unchanged.
- Saturation (ACC_WIDTH=16, DOT_OUTPUT_WIDTH=16):
  - Stimulus: accumulate 0x7000 + 0x7000.
  - Response: with PE_DRAIN_SATURATE_EN, 0x7FFF; without, 0xE000.
- Reset mid-drain:
  - Stimulus: resetn=0 after 2 beats.
  - Response: o_valid, o_stall and o_overflow go 0 immediately; after release, a fresh tile drains correctly from (0,0).
